// File: rtl/ps2_tx_multi_pkg.sv
// Shared types and line-level constants for the multi-channel PS/2 transmitter.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_GAP
  } state_t;

  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;
  localparam logic PARITY_INIT = 1'b1;

endpackage

// File: rtl/ps2_tx_multi_chan.sv
// One PS/2 transmit channel: byte FIFO, overflow flag and the frame serialiser.
module ps2_tx_chan
  import ps2_pkg::*;
#(
  parameter int FIFO_BITS = 3,
  parameter int GAP       = 2
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_clk_ps2,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  input  logic       i_ovf_clr,
  input  logic       i_inhibit,
  output logic       o_full,
  output logic       o_overflow,
  output logic       o_busy,
  output logic       o_ps2_clk,
  output logic       o_ps2_data
);

  localparam int                   DEPTH    = 1 << FIFO_BITS;
  localparam logic [FIFO_BITS:0]   CNT_FULL = (FIFO_BITS + 1)'(DEPTH);
  localparam logic [FIFO_BITS:0]   CNT_ONE  = (FIFO_BITS + 1)'(1);
  localparam logic [FIFO_BITS-1:0] PTR_ONE  = FIFO_BITS'(1);
  localparam logic [3:0]           GAP_INIT = 4'(GAP);

  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_BITS-1:0] r_wptr;
  logic [FIFO_BITS-1:0] r_rptr;
  logic [FIFO_BITS:0]   r_count;
  logic                 r_ovf;
  state_t               r_state;
  logic [7:0]           r_shift;
  logic [2:0]           r_bit;
  logic                 r_par;
  logic [3:0]           r_gap;
  logic                 r_data;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_pop;

  assign w_push = i_wr && (r_count != CNT_FULL);
  assign w_drop = i_wr && (r_count == CNT_FULL);
  assign w_pop  = i_tick && (r_state == ST_STOP);

  always_ff @(posedge clk_sys) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
      if (w_push && !w_pop)      r_count <= r_count + CNT_ONE;
      else if (!w_push && w_pop) r_count <= r_count - CNT_ONE;
      if (w_drop)         r_ovf <= 1'b1;
      else if (i_ovf_clr) r_ovf <= 1'b0;
    end
  end

  // The byte stays in the FIFO until its stop bit, so a host abort simply resends it.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_par   <= PARITY_INIT;
      r_gap   <= '0;
      r_data  <= STOP_BIT;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_tick && (r_count != '0) && !i_inhibit) begin
            r_shift <= r_mem[r_rptr];
            r_par   <= PARITY_INIT;
            r_data  <= START_BIT;
            r_bit   <= '0;
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_inhibit) begin
            r_state <= ST_GAP;
            r_gap   <= GAP_INIT;
            r_data  <= STOP_BIT;
          end else if (i_tick) begin
            r_data  <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_par   <= r_par ^ r_shift[0];
            if (r_bit == 3'd7) r_state <= ST_PARITY;
            else               r_bit   <= r_bit + 3'd1;
          end
        end
        ST_PARITY: begin
          if (i_inhibit) begin
            r_state <= ST_GAP;
            r_gap   <= GAP_INIT;
            r_data  <= STOP_BIT;
          end else if (i_tick) begin
            r_data  <= r_par;
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (i_tick) begin
            r_data  <= STOP_BIT;
            r_gap   <= GAP_INIT;
            r_state <= (GAP == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (i_tick) begin
            r_data <= STOP_BIT;
            r_gap  <= (r_gap == 4'd0) ? 4'd0 : r_gap - 4'd1;
            if (r_gap <= 4'd1) r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_full     = (r_count == CNT_FULL);
  assign o_overflow = r_ovf;
  assign o_busy     = (r_state != ST_IDLE) || (r_count != '0);
  assign o_ps2_clk  = i_clk_ps2 | (r_state == ST_IDLE) | (r_state == ST_GAP);
  assign o_ps2_data = r_data;

endmodule

// File: rtl/ps2_tx_multi.sv
// Multi-channel PS/2 device transmitter: shared bit-rate divider and tick, write decode,
// and NUM_CH independent channels.
module ps2_tx_multi
  import ps2_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int FIFO_BITS = 3,
  parameter int PS2DIV    = 1000,
  parameter int GAP       = 2
) (
  input  logic                                           clk_sys,
  input  logic                                           reset,
  input  logic                                           wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [7:0]                                     wr_data,
  input  logic [NUM_CH-1:0]                              ovf_clr,
  input  logic [NUM_CH-1:0]                              inhibit,
  output logic [NUM_CH-1:0]                              full,
  output logic [NUM_CH-1:0]                              overflow,
  output logic [NUM_CH-1:0]                              busy,
  output logic [NUM_CH-1:0]                              ps2_clk,
  output logic [NUM_CH-1:0]                              ps2_data
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [31:0] r_div;
  logic        r_clk_ps2;
  logic        r_clk_ps2_d;
  logic        w_tick;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_div       <= '0;
      r_clk_ps2   <= 1'b0;
      r_clk_ps2_d <= 1'b0;
    end else begin
      if (r_div == 32'(PS2DIV)) begin
        r_div     <= '0;
        r_clk_ps2 <= ~r_clk_ps2;
      end else begin
        r_div <= r_div + 32'd1;
      end
      r_clk_ps2_d <= r_clk_ps2;
    end
  end

  // Channels drive their data one cycle after this, so it settles well before the falling edge.
  assign w_tick = r_clk_ps2 & ~r_clk_ps2_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    logic w_wr;
    assign w_wr = wr_en && (wr_ch == CH_W'(g));

    ps2_tx_chan #(
      .FIFO_BITS (FIFO_BITS),
      .GAP       (GAP)
    ) u_chan (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .i_tick     (w_tick),
      .i_clk_ps2  (r_clk_ps2),
      .i_wr       (w_wr),
      .i_data     (wr_data),
      .i_ovf_clr  (ovf_clr[g]),
      .i_inhibit  (inhibit[g]),
      .o_full     (full[g]),
      .o_overflow (overflow[g]),
      .o_busy     (busy[g]),
      .o_ps2_clk  (ps2_clk[g]),
      .o_ps2_data (ps2_data[g])
    );
  end

endmodule

// File: tb/tb_ps2_tx_multi.sv
// Scoreboard bench for ps2_tx_multi: writes push expected bytes, a line-level monitor
// decodes frames on the PS/2 clock falling edges and pops/compares.
module tb_ps2_tx_multi;

  localparam int NUM_CH    = 3;
  localparam int FIFO_BITS = 2;
  localparam int PS2DIV    = 1;
  localparam int GAP       = 2;
  localparam int DEPTH     = 1 << FIFO_BITS;
  localparam int TICK      = 2 * (PS2DIV + 1);
  localparam int FRAME_CYC = (11 + GAP) * TICK;

  logic              clk_sys = 1'b0;
  logic              reset   = 1'b1;
  logic              wr_en   = 1'b0;
  logic [1:0]        wr_ch   = '0;
  logic [7:0]        wr_data = '0;
  logic [NUM_CH-1:0] ovf_clr = '0;
  logic [NUM_CH-1:0] inhibit = '0;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] overflow;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] ps2_clk;
  logic [NUM_CH-1:0] ps2_data;

  ps2_tx_multi #(
    .NUM_CH    (NUM_CH),
    .FIFO_BITS (FIFO_BITS),
    .PS2DIV    (PS2DIV),
    .GAP       (GAP)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_data  (wr_data),
    .ovf_clr  (ovf_clr),
    .inhibit  (inhibit),
    .full     (full),
    .overflow (overflow),
    .busy     (busy),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk_sys = ~clk_sys;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  always @(posedge clk_sys) cycle <= cycle + 1;

  // Reference model: per-channel byte streams and FIFO occupancy.
  logic [7:0]        expQ [NUM_CH][$];
  int                modelCount [NUM_CH];
  logic [NUM_CH-1:0] expOvf = '0;

  // Monitor state
  logic       prevClk    [NUM_CH];
  int         nbits      [NUM_CH];
  logic [9:0] bits       [NUM_CH];
  int         idleCnt    [NUM_CH];
  int         stopDue    [NUM_CH];
  int         frameCount [NUM_CH];
  int         abortCount [NUM_CH];
  int         curStart   [NUM_CH];
  int         lastStart  [NUM_CH];
  int         prevStart  [NUM_CH];
  int         parityCyc  [NUM_CH];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Host-side decoder: start, 8 data bits and parity are clocked by falling edges;
  // the stop level is checked one tick later, once the line clock is held high.
  always @(negedge clk_sys) begin : monitor
    logic [7:0] b;
    logic [9:0] expFrame;
    if (reset) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        prevClk[ch] = 1'b1;
        nbits[ch]   = 0;
        idleCnt[ch] = 0;
        stopDue[ch] = -1;
      end
    end else begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (stopDue[ch] > 0) begin
          stopDue[ch]--;
          if (stopDue[ch] == 0) begin
            checkOutput($sformatf("stopData ch%0d", ch), int'(ps2_data[ch]), 1);
            checkOutput($sformatf("stopClk ch%0d", ch), int'(ps2_clk[ch]), 1);
            if (modelCount[ch] > 0) modelCount[ch]--;
            frameCount[ch]++;
            stopDue[ch] = -1;
          end
        end
        if (prevClk[ch] && !ps2_clk[ch]) begin
          if (nbits[ch] == 0) curStart[ch] = cycle;
          bits[ch][nbits[ch]] = ps2_data[ch];
          nbits[ch]++;
          idleCnt[ch] = 0;
          if (nbits[ch] == 10) begin
            nbits[ch]     = 0;
            parityCyc[ch] = cycle;
            prevStart[ch] = lastStart[ch];
            lastStart[ch] = curStart[ch];
            if (expQ[ch].size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpectedFrame ch%0d: got frame %0h, expected no frame", ch, bits[ch]);
            end else begin
              b        = expQ[ch].pop_front();
              expFrame = {~^b, b, 1'b0};
              checkOutput($sformatf("frame ch%0d", ch), int'(bits[ch]), int'(expFrame));
            end
            stopDue[ch] = 4;
          end
        end else if (nbits[ch] != 0) begin
          idleCnt[ch]++;
          if (idleCnt[ch] > 3 * TICK) begin
            nbits[ch] = 0;
            abortCount[ch]++;
          end
        end
        prevClk[ch] = ps2_clk[ch];
      end
    end
  end

  task automatic applyStimulus(input int ch, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_ch   = ch[1:0];
    wr_data = d;
    if (ch < NUM_CH) begin
      if (modelCount[ch] < DEPTH) begin
        expQ[ch].push_back(d);
        modelCount[ch]++;
      end else begin
        expOvf[ch] = 1'b1;
      end
    end
    @(negedge clk_sys);
    wr_en = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic waitFrames(input int ch, input int target, input string name);
    int n = 0;
    while (frameCount[ch] < target && n < 8 * FRAME_CYC + 200) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(name, int'(frameCount[ch] >= target), 1);
  endtask

  task automatic waitIdle(input int ch, input string name);
    int n = 0;
    while (busy[ch] && n < 8 * FRAME_CYC + 200) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(name, int'(busy[ch]), 0);
  endtask

  initial begin : stimulus
    int fc;
    int ab;
    int n;
    int ch;
    logic [7:0] d;

    waitCycles(3);
    checkOutput("resetClk",  int'(ps2_clk),  int'({NUM_CH{1'b1}}));
    checkOutput("resetData", int'(ps2_data), int'({NUM_CH{1'b1}}));
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetFull", int'(full), 0);
    checkOutput("resetOvf",  int'(overflow), 0);
    reset = 1'b0;
    waitCycles(5);

    $display("[TB] basic frame 0xA5 on channel 0");
    applyStimulus(0, 8'hA5);
    checkOutput("busyRise", int'(busy[0]), 1);
    waitFrames(0, 1, "basicFrameDone");
    waitIdle(0, "basicIdle");

    $display("[TB] back-to-back 0x00, 0xFF");
    fc = frameCount[0];
    applyStimulus(0, 8'h00);
    applyStimulus(0, 8'hFF);
    waitFrames(0, fc + 2, "b2bDone");
    checkOutput("b2bSpacing", lastStart[0] - prevStart[0], FRAME_CYC);
    n = 0;
    while (busy[0] && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("busyFallDelay", cycle - parityCyc[0], (PS2DIV + 1) + 1 + GAP * TICK);

    $display("[TB] overflow on channel 1");
    fc = frameCount[1];
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1, 8'(8'h40 + i));
      checkOutput($sformatf("full w%0d", i), int'(full[1]), int'(modelCount[1] == DEPTH));
      checkOutput($sformatf("ovf w%0d", i), int'(overflow[1]), int'(expOvf[1]));
    end
    ovf_clr[1] = 1'b1;
    @(negedge clk_sys);
    ovf_clr[1] = 1'b0;
    expOvf[1]  = 1'b0;
    checkOutput("ovfClear", int'(overflow[1]), 0);
    waitFrames(1, fc + DEPTH, "ovfFramesDone");
    waitIdle(1, "ovfIdle");

    $display("[TB] inhibit retransmit 0x3C");
    fc = frameCount[0];
    ab = abortCount[0];
    applyStimulus(0, 8'h3C);
    n = 0;
    while (nbits[0] < 4 && n < 4 * FRAME_CYC) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("reachBit3", int'(nbits[0] >= 4), 1);
    waitCycles(3);
    inhibit[0] = 1'b1;
    waitCycles(2);
    checkOutput("abortClk",  int'(ps2_clk[0]), 1);
    checkOutput("abortData", int'(ps2_data[0]), 1);
    checkOutput("abortBusy", int'(busy[0]), 1);
    waitCycles(5 * TICK - 2);
    checkOutput("inhibitClk", int'(ps2_clk[0]), 1);
    inhibit[0] = 1'b0;
    waitFrames(0, fc + 1, "resendDone");
    checkOutput("abortSeen", abortCount[0] - ab, 1);
    waitIdle(0, "inhibitIdle");

    $display("[TB] channel independence");
    applyStimulus(2, 8'h12);
    applyStimulus(0, 8'h34);
    for (int i = 0; i < 8; i++) begin
      waitCycles(TICK);
      checkOutput("ch1Busy", int'(busy[1]), 0);
      checkOutput("ch1Clk",  int'(ps2_clk[1]), 1);
    end
    waitIdle(2, "indepIdle2");
    waitIdle(0, "indepIdle0");

    $display("[TB] random traffic");
    for (int i = 0; i < 40; i++) begin
      ch = int'($urandom_range(0, 3));
      d  = 8'($urandom);
      if (ch >= NUM_CH || modelCount[ch] < DEPTH) applyStimulus(ch, d);
      waitCycles(int'($urandom_range(0, 40)));
    end
    n = 0;
    while ((busy != '0 || expQ[0].size() != 0 || expQ[1].size() != 0 || expQ[2].size() != 0)
           && n < 40 * FRAME_CYC) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("randomDrained", int'(busy), 0);
    checkOutput("randomOvf", int'(overflow), int'(expOvf));

    $display("[TB] mid-frame reset");
    applyStimulus(2, 8'h5A);
    n = 0;
    while (nbits[2] < 9 && n < 4 * FRAME_CYC) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("reachParity", int'(nbits[2] >= 9), 1);
    waitCycles(3);
    reset = 1'b1;
    #1;
    checkOutput("midResetClk",  int'(ps2_clk),  int'({NUM_CH{1'b1}}));
    checkOutput("midResetData", int'(ps2_data), int'({NUM_CH{1'b1}}));
    checkOutput("midResetBusy", int'(busy), 0);
    waitCycles(3);
    reset = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      expQ[c].delete();
      modelCount[c] = 0;
    end
    expOvf = '0;
    fc = frameCount[2];
    waitCycles(3 * FRAME_CYC);
    checkOutput("noFrameAfterReset", frameCount[2], fc);
    checkOutput("idleAfterReset", int'(busy), 0);

    for (int c = 0; c < NUM_CH; c++)
      checkOutput($sformatf("queueEmpty ch%0d", c), expQ[c].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
